// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback: register-file write, forwarding, retire trace and counters.
// Optional commit trace (pc/inst payload, commit outputs, instret) built only with MEM_WB_COMMIT_TRACE_EN.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [63:0] instaddr_i,
  input  logic [31:0] inst_i,
  input  logic        RFwe_i,
  input  logic [4:0]  rdaddr_i,
  input  logic [63:0] rd_wdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [63:0] rf_wdata_o,
  output logic        fwd_valid_o,
  output logic [4:0]  fwd_addr_o,
  output logic [63:0] fwd_data_o,
  output logic        commit_valid_o,
  output logic [63:0] commit_pc_o,
  output logic [31:0] commit_inst_o,
  output logic [63:0] instret_o,
  output logic [63:0] mcycle_o
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned RW   = 5;

  logic            v;
  logic            done;
  logic            we;
  logic [RW-1:0]   rd;
  logic [XLEN-1:0] data;
  logic [XLEN-1:0] mcycle;
  logic            commit_c;
  logic            capture_c;
  logic            rd_nz_c;

  assign commit_c  = v && !done;
  assign capture_c = valid_i && !stall_i && !flush_i;
  assign rd_nz_c   = (rd != RW'(0));

  // Entry state: flush beats stall beats capture; a stalled entry commits only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v      <= 1'b0;
      done   <= 1'b0;
      we     <= 1'b0;
      rd     <= '0;
      data   <= '0;
      mcycle <= '0;
    end else begin
      mcycle <= mcycle + XLEN'(1);
      if (flush_i) begin
        v    <= 1'b0;
        done <= 1'b0;
      end else if (stall_i) begin
        if (commit_c) done <= 1'b1;
      end else if (valid_i) begin
        v    <= 1'b1;
        done <= 1'b0;
        we   <= RFwe_i;
        rd   <= rdaddr_i;
        data <= rd_wdata_i;
      end else begin
        v    <= 1'b0;
        done <= 1'b0;
      end
    end
  end

  assign rf_we_o     = commit_c && we && rd_nz_c;
  assign rf_waddr_o  = rd;
  assign rf_wdata_o  = data;
  assign fwd_valid_o = v && we && rd_nz_c;
  assign fwd_addr_o  = rd;
  assign fwd_data_o  = data;
  assign mcycle_o    = mcycle;

`ifdef MEM_WB_COMMIT_TRACE_EN
  logic [XLEN-1:0] pc;
  logic [31:0]     inst;
  logic [XLEN-1:0] instret;

  // Retire trace; instret counts edges that close a commit cycle, even under flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      inst    <= '0;
      instret <= '0;
    end else begin
      if (capture_c) begin
        pc   <= instaddr_i;
        inst <= inst_i;
      end
      if (commit_c) instret <= instret + XLEN'(1);
    end
  end

  assign commit_valid_o = commit_c;
  assign commit_pc_o    = pc;
  assign commit_inst_o  = inst;
  assign instret_o      = instret;
`else
  logic unused_trace;
  assign unused_trace   = ^{instaddr_i, inst_i, capture_c};
  assign commit_valid_o = 1'b0;
  assign commit_pc_o    = '0;
  assign commit_inst_o  = '0;
  assign instret_o      = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; trace expectations follow MEM_WB_COMMIT_TRACE_EN.
module tb_mem_wb_stage;

`ifdef MEM_WB_COMMIT_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [63:0] instaddr_i;
  logic [31:0] inst_i;
  logic        RFwe_i;
  logic [4:0]  rdaddr_i;
  logic [63:0] rd_wdata_i;
  logic        stall_i;
  logic        flush_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [63:0] rf_wdata_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [63:0] fwd_data_o;
  logic        commit_valid_o;
  logic [63:0] commit_pc_o;
  logic [31:0] commit_inst_o;
  logic [63:0] instret_o;
  logic [63:0] mcycle_o;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_mc;
  logic [63:0] exp_ir;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .instaddr_i(instaddr_i), .inst_i(inst_i),
    .RFwe_i(RFwe_i), .rdaddr_i(rdaddr_i), .rd_wdata_i(rd_wdata_i), .stall_i(stall_i),
    .flush_i(flush_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .commit_inst_o(commit_inst_o),
    .instret_o(instret_o), .mcycle_o(mcycle_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    exp_mc = exp_mc + 64'd1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [63:0] d, input logic we);
    valid_i    = v;
    rdaddr_i   = rd;
    rd_wdata_i = d;
    RFwe_i     = we;
    instaddr_i = 64'h1000 + 64'(rd);
    inst_i     = 32'h0000_0013 | (32'(rd) << 7);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rf_we"},   64'(rf_we_o), 64'd0);
    check({tag, ".waddr"},   64'(rf_waddr_o), 64'd0);
    check({tag, ".wdata"},   rf_wdata_o, 64'd0);
    check({tag, ".fwd_v"},   64'(fwd_valid_o), 64'd0);
    check({tag, ".fwd_d"},   fwd_data_o, 64'd0);
    check({tag, ".commit"},  64'(commit_valid_o), 64'd0);
    check({tag, ".pc"},      commit_pc_o, 64'd0);
    check({tag, ".instret"}, instret_o, 64'd0);
    check({tag, ".mcycle"},  mcycle_o, 64'd0);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    instaddr_i = 64'd0; inst_i = 32'd0;
    exp_mc = 64'd0; exp_ir = 64'd0;
    @(posedge clk); #1;
    check_all_zero("reset");
    rst = 1'b0;

    // single instruction rd=5
    drive(1'b1, 5'd5, 64'h1234, 1'b1);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    check("s1.rf_we",   64'(rf_we_o), 64'd1);
    check("s1.waddr",   64'(rf_waddr_o), 64'd5);
    check("s1.wdata",   rf_wdata_o, 64'h1234);
    check("s1.commit",  64'(commit_valid_o), 64'(TR));
    check("s1.pc",      commit_pc_o, TR ? 64'h1005 : 64'd0);
    check("s1.inst",    64'(commit_inst_o), TR ? 64'h293 : 64'd0);
    check("s1.ir0",     instret_o, 64'd0);
    check("s1.mcycle",  mcycle_o, exp_mc);
    step(); exp_ir++;
    check("s1.ir1",     instret_o, TR ? exp_ir : 64'd0);
    check("s1.rf_we_off", 64'(rf_we_o), 64'd0);
    check("s1.commit_off", 64'(commit_valid_o), 64'd0);

    // rd=7 then stall for 4 cycles
    drive(1'b1, 5'd7, 64'hABCD, 1'b1);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    stall_i = 1'b1;
    check("s2.c1.rf_we",  64'(rf_we_o), 64'd1);
    check("s2.c1.commit", 64'(commit_valid_o), 64'(TR));
    check("s2.c1.fwd_v",  64'(fwd_valid_o), 64'd1);
    check("s2.c1.fwd_a",  64'(fwd_addr_o), 64'd7);
    exp_ir++;
    for (int i = 0; i < 4; i++) begin
      step();
      check("s2.st.rf_we",  64'(rf_we_o), 64'd0);
      check("s2.st.commit", 64'(commit_valid_o), 64'd0);
      check("s2.st.fwd_v",  64'(fwd_valid_o), 64'd1);
      check("s2.st.fwd_a",  64'(fwd_addr_o), 64'd7);
      check("s2.st.fwd_d",  fwd_data_o, 64'hABCD);
      check("s2.st.ir",     instret_o, TR ? exp_ir : 64'd0);
    end
    stall_i = 1'b0;
    step();
    check("s2.drop.fwd_v", 64'(fwd_valid_o), 64'd0);
    check("s2.ir",         instret_o, TR ? exp_ir : 64'd0);

    // x0 destination retires without writing or forwarding
    drive(1'b1, 5'd0, 64'hFF, 1'b1);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    check("x0.rf_we",  64'(rf_we_o), 64'd0);
    check("x0.fwd_v",  64'(fwd_valid_o), 64'd0);
    check("x0.commit", 64'(commit_valid_o), 64'(TR));
    check("x0.wdata",  rf_wdata_o, 64'hFF);
    step(); exp_ir++;
    check("x0.ir",     instret_o, TR ? exp_ir : 64'd0);

    // back-to-back captures, then flush+stall+valid at an edge closing a commit
    drive(1'b1, 5'd1, 64'h11, 1'b1);
    step();
    check("b2b.a.waddr", 64'(rf_waddr_o), 64'd1);
    check("b2b.a.rf_we", 64'(rf_we_o), 64'd1);
    drive(1'b1, 5'd2, 64'h22, 1'b1);
    step(); exp_ir++;
    check("b2b.b.waddr", 64'(rf_waddr_o), 64'd2);
    check("b2b.b.wdata", rf_wdata_o, 64'h22);
    check("b2b.b.rf_we", 64'(rf_we_o), 64'd1);
    check("b2b.b.commit", 64'(commit_valid_o), 64'(TR));
    drive(1'b1, 5'd9, 64'h99, 1'b1);
    stall_i = 1'b1; flush_i = 1'b1;
    step(); exp_ir++;
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    stall_i = 1'b0; flush_i = 1'b0;
    check("fl.rf_we",  64'(rf_we_o), 64'd0);
    check("fl.commit", 64'(commit_valid_o), 64'd0);
    check("fl.fwd_v",  64'(fwd_valid_o), 64'd0);
    check("fl.ir",     instret_o, TR ? exp_ir : 64'd0);
    step();
    check("fl.ir2",    instret_o, TR ? exp_ir : 64'd0);
    check("fl.mcycle", mcycle_o, exp_mc);

    // reset asserted mid-stall with a committed entry held
    drive(1'b1, 5'd12, 64'h55, 1'b1);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b0);
    stall_i = 1'b1;
    step();
    check("rs.held.fwd_v", 64'(fwd_valid_o), 64'd1);
    check("rs.held.rf_we", 64'(rf_we_o), 64'd0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rs.async");
    @(posedge clk); #1;
    stall_i = 1'b0;
    rst = 1'b0;
    exp_mc = 64'd0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("rs.mcycle", mcycle_o, 64'(i));
      check("rs.fwd_v",  64'(fwd_valid_o), 64'd0);
      check("rs.ir",     instret_o, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
